// File: rtl/barret_1997_arbiter.sv
// Round-robin front end sharing one combinational mod-1997 reducer among
// NREQ requesters, with a two-stage (operand register, output register)
// pipeline and valid/ready backpressure on the response channel.

// Combinational Barrett reduction of a 21-bit operand modulo 1997.
// MU = floor(2^32 / 1997); the estimated quotient is never above the true
// quotient, so at most a couple of corrective subtractions are needed.
module barret_for_1997 (
    input  logic [20:0] din_a,
    output logic [10:0] dout
);
    localparam logic [21:0] MU  = 22'd2150709;
    localparam logic [21:0] MOD = 22'd1997;

    logic [42:0] prod;
    logic [10:0] quot;
    logic [21:0] quot_mod;
    logic [21:0] rem0;
    logic [21:0] rem1;
    logic [21:0] rem2;

    // Estimate the quotient, subtract its multiple, then correct the remainder.
    always_comb begin
        prod     = {22'd0, din_a} * {21'd0, MU};
        quot     = 11'(prod >> 32);
        quot_mod = {11'd0, quot} * MOD;
        rem0     = {1'b0, din_a} - quot_mod;
        rem1     = (rem0 >= MOD) ? (rem0 - MOD) : rem0;
        rem2     = (rem1 >= MOD) ? (rem1 - MOD) : rem1;
        dout     = 11'(rem2);
    end
endmodule

module barret_1997_arbiter #(
    parameter int NREQ   = 4,
    parameter int IDW    = $clog2(NREQ),
    parameter int DIN_W  = 21,
    parameter int DOUT_W = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DIN_W-1:0]   req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DOUT_W-1:0]       rsp_data,
    output logic [IDW-1:0]          rsp_id
);
    logic              s1_valid_q, s1_valid_d;
    logic [DIN_W-1:0]  s1_data_q,  s1_data_d;
    logic [IDW-1:0]    s1_id_q,    s1_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DOUT_W-1:0] rsp_data_q,  rsp_data_d;
    logic [IDW-1:0]    rsp_id_q,    rsp_id_d;
    logic [IDW-1:0]    ptr_q,       ptr_d;

    logic              out_free;
    logic              s1_free;
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand_idx;
    logic [DIN_W-1:0]  grant_data;
    logic [DOUT_W-1:0] red_out;

    barret_for_1997 u_reducer (
        .din_a (s1_data_q),
        .dout  (red_out)
    );

    assign out_free  = !rsp_valid_q || rsp_ready;
    assign s1_free   = !s1_valid_q || out_free;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

    // Pick the first valid requester at or after ptr (wrapping) when S1 can take an operand.
    always_comb begin
        req_ready   = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        if (s1_free && !rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cand_idx = IDW'((int'(ptr_q) + i) % NREQ);
                if (!grant_found && req_valid[cand_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Steer the granted requester's operand toward S1.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                grant_data = req_data[k*DIN_W +: DIN_W];
            end
        end
    end

    // Next-state for both pipeline stages and the round-robin pointer.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;

        if (grant_found) begin
            s1_valid_d = 1'b1;
            s1_data_d  = grant_data;
            s1_id_d    = grant_idx;
            ptr_d      = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (s1_free) begin
            s1_valid_d = 1'b0;
        end

        if (out_free) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_data_d = red_out;
                rsp_id_d   = s1_id_q;
            end
        end
    end

    // Register state; reset discards anything in flight and restarts arbitration at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end
endmodule

// File: tb/tb_barret_1997_arbiter.sv
module tb_barret_1997_arbiter;
   localparam int NREQ = 4;

   typedef struct {
      int res;
      int id;
      int acc;
   } item_t;

   typedef struct {
      int data;
      int id;
      int cyc;
   } rsp_t;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   reqValid;
   logic [NREQ-1:0]   reqReady;
   logic [NREQ*21-1:0] reqData;
   logic              rspValid;
   logic              rspReady;
   logic [10:0]       rspData;
   logic [1:0]        rspId;

   logic [20:0]       reqOps [NREQ];
   logic [20:0]       stageOps [NREQ];
   logic [NREQ-1:0]   lastReady;

   int vecCount;
   int missCount;
   int cyc;

   item_t mq[$];
   int    mptr;
   int    grantLog[$];
   rsp_t  rspLog[$];

   barret_1997_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_data  (reqData),
      .rsp_valid (rspValid),
      .rsp_ready (rspReady),
      .rsp_data  (rspData),
      .rsp_id    (rspId)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pack the per-requester operands into the flat data bus.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         reqData[k*21 +: 21] = reqOps[k];
      end
   end

   // Hard stop in case something never drains.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      vecCount++;
      if (got !== want) begin
         missCount++;
         $display("[TB] FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, then wait past the falling edge.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rr);
      @(posedge clk);
      #1;
      reqValid = v;
      rspReady = rr;
      for (int k = 0; k < NREQ; k++) reqOps[k] = stageOps[k];
      @(negedge clk);
      #1;
      lastReady = reqReady;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      reqValid = '0;
      rspReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      rspReady = 1'b1;
      grantLog.delete();
      rspLog.delete();
   endtask

   // Behavioural model: queue of accepted items in order; the oldest item is
   // visible on the response port once one edge has passed since its accept.
   // A new grant is blocked only when two items are in flight and the consumer stalls.
   initial begin
      logic [NREQ-1:0] expReady;
      logic            expRv;
      logic            freeSlot;
      logic            pendPop;
      logic            pendGrant;
      int              pendId;
      int              pendOp;
      int              k;
      forever begin
         @(negedge clk);
         pendPop   = 1'b0;
         pendGrant = 1'b0;
         pendId    = 0;
         pendOp    = 0;
         if (rst) begin
            checkOutput("rst_req_ready", reqReady, 0);
            checkOutput("rst_rsp_valid", rspValid, 0);
            checkOutput("rst_rsp_data", rspData, 0);
            checkOutput("rst_rsp_id", rspId, 0);
         end else begin
            expRv    = (mq.size() > 0) && (mq[0].acc < cyc);
            freeSlot = !((mq.size() >= 2) && !rspReady);
            expReady = '0;
            if (freeSlot) begin
               for (int j = 0; j < NREQ; j++) begin
                  k = (mptr + j) % NREQ;
                  if (reqValid[k] && expReady == '0) begin
                     expReady[k] = 1'b1;
                     pendId      = k;
                     pendOp      = int'(reqOps[k]);
                  end
               end
            end
            checkOutput("req_ready", reqReady, expReady);
            checkOutput("rsp_valid", rspValid, expRv);
            if (expRv && rspValid) begin
               checkOutput("rsp_data", rspData, mq[0].res);
               checkOutput("rsp_id", rspId, mq[0].id);
            end
            pendPop   = expRv && rspReady;
            pendGrant = (expReady != '0);
            for (int j = 0; j < NREQ; j++) begin
               if (reqReady[j]) grantLog.push_back(j);
            end
            if (rspValid && rspReady) begin
               rspLog.push_back('{data: int'(rspData), id: int'(rspId), cyc: cyc});
            end
         end
         @(posedge clk);
         cyc++;
         if (rst) begin
            mq.delete();
            mptr = 0;
         end else begin
            if (pendPop) void'(mq.pop_front());
            if (pendGrant) begin
               mq.push_back('{res: pendOp % 1997, id: pendId, acc: cyc});
               mptr = (pendId + 1) % NREQ;
            end
         end
      end
   end

   initial begin
      int t1Ops [5];
      int t1Exp [5];
      int t3Exp [5];
      int nextOp;
      int guard;
      int accCount;
      logic [NREQ-1:0] haveOp;

      vecCount  = 0;
      missCount = 0;
      cyc       = 0;
      mptr      = 0;
      rst       = 1'b1;
      reqValid  = '0;
      rspReady  = 1'b0;
      lastReady = '0;
      for (int k = 0; k < NREQ; k++) begin
         reqOps[k]   = '0;
         stageOps[k] = '0;
      end

      // Single requester, boundary operands, consecutive cycles.
      t1Ops = '{0, 1996, 1997, 3993, 2097151};
      t1Exp = '{0, 1996, 0, 1996, 301};
      doReset();
      for (int i = 0; i < 5; i++) begin
         stageOps[0] = 21'(t1Ops[i]);
         applyStimulus(4'b0001, 1'b1);
      end
      repeat (4) applyStimulus(4'b0000, 1'b1);
      checkOutput("t1_count", rspLog.size(), 5);
      if (rspLog.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            checkOutput("t1_data", rspLog[i].data, t1Exp[i]);
            checkOutput("t1_id", rspLog[i].id, 0);
            checkOutput("t1_nogap", rspLog[i].cyc - rspLog[0].cyc, i);
         end
      end

      // All requesters valid: strict rotation, ids follow.
      doReset();
      for (int k = 0; k < NREQ; k++) stageOps[k] = 21'(100 + k);
      repeat (8) applyStimulus(4'b1111, 1'b1);
      repeat (4) applyStimulus(4'b0000, 1'b1);
      checkOutput("t2_grants", grantLog.size(), 8);
      checkOutput("t2_rsps", rspLog.size(), 8);
      if (grantLog.size() == 8 && rspLog.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            checkOutput("t2_grant", grantLog[i], i % 4);
            checkOutput("t2_rsp_id", rspLog[i].id, i % 4);
            checkOutput("t2_rsp_data", rspLog[i].data, 100 + (i % 4));
         end
      end

      // Sparse fairness, then requester 0 joins right after a grant to 3.
      t3Exp = '{1, 3, 1, 3, 0};
      doReset();
      for (int k = 0; k < NREQ; k++) stageOps[k] = 21'(2000 + k);
      repeat (4) applyStimulus(4'b1010, 1'b1);
      applyStimulus(4'b1011, 1'b1);
      repeat (4) applyStimulus(4'b0000, 1'b1);
      checkOutput("t3_grants", grantLog.size(), 5);
      if (grantLog.size() == 5) begin
         for (int i = 0; i < 5; i++) checkOutput("t3_grant", grantLog[i], t3Exp[i]);
      end

      // Backpressure on a stream from requester 2.
      doReset();
      nextOp      = 5000;
      stageOps[2] = 21'(nextOp);
      for (int i = 0; i < 14; i++) begin
         applyStimulus(4'b0100, (i < 3 || i >= 8) ? 1'b1 : 1'b0);
         if (i >= 3 && i < 8) checkOutput("t4_stall_ready", reqReady, 0);
         if (lastReady[2]) begin
            nextOp++;
            stageOps[2] = 21'(nextOp);
         end
      end
      repeat (4) applyStimulus(4'b0000, 1'b1);
      checkOutput("t4_grants", grantLog.size(), 9);
      checkOutput("t4_rsps", rspLog.size(), 9);
      if (rspLog.size() == 9) begin
         for (int i = 0; i < 9; i++) begin
            checkOutput("t4_data", rspLog[i].data, (5000 + i) % 1997);
            checkOutput("t4_id", rspLog[i].id, 2);
         end
      end

      // Sweep 0..3993 across all requesters with random backpressure.
      doReset();
      nextOp = 0;
      for (int k = 0; k < NREQ; k++) begin
         stageOps[k] = 21'(nextOp);
         nextOp++;
      end
      haveOp   = 4'b1111;
      guard    = 0;
      accCount = 0;
      while (haveOp != '0 && guard < 20000) begin
         applyStimulus(haveOp, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
         for (int k = 0; k < NREQ; k++) begin
            if (lastReady[k]) begin
               accCount++;
               if (nextOp <= 3993) begin
                  stageOps[k] = 21'(nextOp);
                  nextOp++;
               end else begin
                  haveOp[k] = 1'b0;
               end
            end
         end
         guard++;
      end
      checkOutput("t5_no_timeout", (guard < 20000) ? 1 : 0, 1);
      repeat (4) applyStimulus(4'b0000, 1'b1);
      checkOutput("t5_accepts", accCount, 3994);
      checkOutput("t5_rsps", rspLog.size(), 3994);

      // Asynchronous reset in the middle of a stream.
      doReset();
      for (int k = 0; k < NREQ; k++) stageOps[k] = 21'(700 + k);
      repeat (3) applyStimulus(4'b1111, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("t6_rsp_valid_drop", rspValid, 0);
      checkOutput("t6_ready_in_reset", reqReady, 0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      reqValid = 4'b0110;
      rspReady = 1'b1;
      grantLog.delete();
      rspLog.delete();
      @(negedge clk);
      #1;
      checkOutput("t6_first_grant", reqReady, 4'b0010);
      applyStimulus(4'b0110, 1'b1);
      repeat (4) applyStimulus(4'b0000, 1'b1);
      checkOutput("t6_rsps", rspLog.size(), 2);
      if (rspLog.size() == 2) begin
         checkOutput("t6_id0", rspLog[0].id, 1);
         checkOutput("t6_id1", rspLog[1].id, 2);
         checkOutput("t6_data0", rspLog[0].data, 701);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule

// File: doc/barret_1997_arbiter.md
# barret_1997_arbiter

Round-robin front end that shares one combinational `barret_for_1997` reducer (21-bit operand in, 11-bit residue mod 1997 out) among NREQ independent requesters. Each requester presents an operand with a valid/ready handshake. The block registers the granted operand, reduces it, and returns the residue tagged with the requester index on a single response channel with backpressure. It sits between the NTT/multiplier lanes and the shared reduction resource.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester index, = clog2(NREQ)
- DIN_W, 21, operand width (fixed by reducer)
- DOUT_W, 11, residue width (fixed by reducer)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_data  in  NREQ*DIN_W  operands; requester k uses bits [k*DIN_W +: DIN_W]
- rsp_valid  out  1  residue valid
- rsp_ready  in  1  downstream accept
- rsp_data  out  DOUT_W  residue = operand mod 1997, range 0..1996
- rsp_id  out  IDW  index of the requester that issued the operand

## Operation
- Two-stage pipeline:
  - S1 holds s1_valid, s1_data[20:0] and s1_id.
  - S2 is the output register: rsp_valid, rsp_data, rsp_id.
  - The reducer is instantiated once, combinationally between S1 and S2 (din_a = s1_data).
- Stall logic:
  - out_free = !rsp_valid | rsp_ready.
  - s1_free = !s1_valid | out_free.
- Arbitration (combinational):
  - When s1_free, scan req_valid starting at index ptr, wrapping modulo NREQ. The first set bit k gets req_ready[k] = 1. All other bits are 0.
  - When !s1_free, req_ready = 0.
  - req_ready depends combinationally on rsp_ready. This path is intentional.
- Accept (req_valid[k] & req_ready[k]) at an edge:
  - s1_data <= operand k, s1_id <= k, s1_valid <= 1.
  - ptr <= (k+1) mod NREQ.
- ptr moves only on accept. An idle cycle leaves ptr unchanged.
- S1 and S2 transfers:
  - If s1_free and no accept, then s1_valid <= 0 only when S1 is advancing or empty.
  - If out_free, then rsp_valid <= s1_valid. When s1_valid, rsp_data <= reducer output and rsp_id <= s1_id.
  - If !out_free, S2 holds all values and S1 holds.
- Simultaneous accept into S1 and S1→S2 transfer in the same cycle is required. Sustained throughput is 1 operand/cycle.
- Arithmetic:
  - Any 21-bit operand 0..2097151 is legal.
  - No saturation and no error flag.
  - rsp_data is always < 1997.
- Ordering: responses leave in acceptance order. No reordering and no drops.
- Held-response rule: while rsp_valid & !rsp_ready, rsp_data and rsp_id stay stable.
- Requester protocol: a requester may drop req_valid while not granted. The arbiter assumes nothing about operand stability before acceptance.

## Timing
- Reset (rst high, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0, s1_valid=0, s1_data=0, s1_id=0, ptr=0.
  - req_ready=0 while rst is high.
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is emitted for them. After rst falls, the first grant goes from ptr=0.
- Latency: operand accepted at edge T → rsp_valid high after edge T+1 (2-cycle latency with no stall).
- Each stall cycle on rsp_ready adds exactly one cycle of latency to every in-flight item.
- When both stages are full and rsp_ready=0, all req_ready=0 in that cycle.
- Fill/drain: from empty, a burst of N accepts produces N responses on N consecutive cycles, starting 2 cycles after the first accept, provided rsp_ready=1.

## Test plan
- Single requester 0, rsp_ready=1, operands 0, 1996, 1997, 3993, 2097151 on consecutive cycles → rsp_data 0, 1996, 0, 1996, 301 with rsp_id=0. Each response appears 2 cycles after its accept, with no gaps.
- All four req_valid held high → grants in order 0,1,2,3,0,1,… with exactly one req_ready bit per cycle. rsp_id follows the same sequence, delayed 2 cycles.
- Sparse fairness: only requesters 1 and 3 valid → grants alternate 1,3,1,3. Then raise requester 0 right after a grant to 3 → next grant is 0.
- Backpressure: stream from requester 2, then drop rsp_ready for 5 cycles.
  - rsp_data and rsp_id must stay frozen.
  - req_ready goes 0 once both stages are full.
  - After rsp_ready rises, the sequence resumes with no loss or duplication.
- Exhaustive sweep: operands 0..3993 rotated across all requesters with random rsp_ready → every response equals operand mod 1997 and carries the correct id, in order.
- Asynchronous reset asserted mid-stream, between clock edges → rsp_valid falls immediately and nothing from before reset is emitted afterward. The next grant goes to the lowest valid index ≥ 0.
